// File: rtl/press_pkg.sv
// rtl/press_pkg.sv - shared state type and default constants for the press debouncer
package press_pkg;

    typedef enum logic [1:0] {
        PD_IDLE,
        PD_CHECK_DN,
        PD_PRESSED,
        PD_CHECK_UP
    } pd_state_t;

    localparam int PD_DEBOUNCE_CYCLES = 16;
    localparam int PD_LONG_CYCLES     = 64;
    localparam int PD_CNT_W           = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule

// File: rtl/press_debounce.sv
// rtl/press_debounce.sv - synchronise and debounce a push button into a clean level and edge pulses
// Long-press detection is compiled in only when LONG_PRESS_EN is defined.
module press_debounce
    import press_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PD_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = PD_LONG_CYCLES,
    parameter int CNT_W           = PD_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic press_raw,
    output logic press_clean,
    output logic press_rise,
    output logic press_fall,
    output logic long_press,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync;
    pd_state_t        r_state;
    pd_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic             r_clean;
    logic             w_clean_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             w_hold_run;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (press_raw),
        .o_q (w_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= PD_IDLE;
            r_db_cnt <= '0;
            r_clean  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
            r_clean  <= w_clean_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
        end
    end

    // db_cnt is zeroed on every state change so each check window starts fresh
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_clean_nxt  = r_clean;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        case (r_state)
            PD_IDLE: begin
                if (w_sync) begin
                    w_state_nxt  = PD_CHECK_DN;
                    w_db_cnt_nxt = '0;
                end
            end
            PD_CHECK_DN: begin
                if (!w_sync) begin
                    w_state_nxt  = PD_IDLE;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_MAX) begin
                    w_state_nxt  = PD_PRESSED;
                    w_db_cnt_nxt = '0;
                    w_clean_nxt  = 1'b1;
                    w_rise_nxt   = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            PD_PRESSED: begin
                if (!w_sync) begin
                    w_state_nxt  = PD_CHECK_UP;
                    w_db_cnt_nxt = '0;
                end
            end
            PD_CHECK_UP: begin
                if (w_sync) begin
                    w_state_nxt  = PD_PRESSED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_MAX) begin
                    w_state_nxt  = PD_IDLE;
                    w_db_cnt_nxt = '0;
                    w_clean_nxt  = 1'b0;
                    w_fall_nxt   = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = PD_IDLE;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    assign w_hold_run = (r_state == PD_PRESSED) && w_sync;

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_long;
    logic             r_held;

    // hold_cnt saturates; r_held doubles as the once-per-press flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_rise_nxt || w_fall_nxt) begin
                r_hold_cnt <= '0;
            end else if (w_hold_run) begin
                if (r_hold_cnt != LONG_MAX) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end else if (!r_held) begin
                    r_long <= 1'b1;
                    r_held <= 1'b1;
                end
            end
            if (w_fall_nxt) begin
                r_held <= 1'b0;
            end
        end
    end

    assign long_press = r_long;
    assign held       = r_held;
`else
    logic w_unused;
    assign w_unused   = w_hold_run;
    assign long_press = 1'b0;
    assign held       = 1'b0;
`endif

    assign press_clean = r_clean;
    assign press_rise  = r_rise;
    assign press_fall  = r_fall;

endmodule

// File: tb/tb_press_debounce.sv
// tb/tb_press_debounce.sv - self-checking bench for press_debounce against a run-length reference model
module tb_press_debounce;

    localparam int D = 4;
    localparam int L = 8;
`ifdef LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic press_raw;
    logic press_clean;
    logic press_rise;
    logic press_fall;
    logic long_press;
    logic held;

    int tests = 0;
    int fails = 0;

    // reference model: a level flips once D+1 consecutive synchronised samples disagree with it
    logic m_s1, m_s2, m_clean, m_held;
    int   m_run, m_hold;
    logic e_rise, e_fall, e_long;
    int   n_rise, n_fall, n_long;

    press_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .press_raw   (press_raw),
        .press_clean (press_clean),
        .press_rise  (press_rise),
        .press_fall  (press_fall),
        .long_press  (long_press),
        .held        (held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic raw, input logic r);
        logic smp;
        e_rise = 1'b0;
        e_fall = 1'b0;
        e_long = 1'b0;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_clean = 1'b0; m_held = 1'b0;
            m_run = 0; m_hold = 0;
        end else begin
            smp  = m_s2;
            m_s2 = m_s1;
            m_s1 = raw;
            if (smp != m_clean) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_clean = smp;
                    m_run   = 0;
                    if (smp) begin
                        e_rise = 1'b1;
                        m_hold = 0;
                    end else begin
                        e_fall = 1'b1;
                        m_held = 1'b0;
                    end
                end
            end else begin
                if (m_clean && m_run == 0) begin
                    m_hold++;
                    if (m_hold == L && LONG_EN) begin
                        e_long = 1'b1;
                        m_held = 1'b1;
                    end
                end
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic raw, input logic r);
        @(negedge clk);
        press_raw = raw;
        rst       = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
        chk("press_clean", press_clean, m_clean);
        chk("press_rise", press_rise, e_rise);
        chk("press_fall", press_fall, e_fall);
        chk("long_press", long_press, e_long);
        chk("held", held, m_held);
        chk("rise_fall_exclusive", press_rise & press_fall, 1'b0);
        if (press_rise) n_rise++;
        if (press_fall) n_fall++;
        if (long_press) n_long++;
    endtask

    task automatic clear_counts();
        n_rise = 0;
        n_fall = 0;
        n_long = 0;
    endtask

    initial begin
        int rise_at;
        logic lvl;
        int len;

        rst = 1'b1;
        press_raw = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_clean = 1'b0; m_held = 1'b0;
        m_run = 0; m_hold = 0;
        clear_counts();

        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("reset_clean", press_clean, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // clean press: rise expected after edge 6 counting from the first raw-high edge
        clear_counts();
        rise_at = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            if (press_rise && rise_at < 0) rise_at = i;
        end
        chk_int("clean_rise_edge", rise_at, D + 2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk_int("clean_rise_count", n_rise, 1);
        chk_int("clean_fall_count", n_fall, 1);

        // bounce shorter than the debounce window
        clear_counts();
        for (int i = 0; i < 8; i++) step(((i / 2) % 2) == 0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk_int("bounce_rise_count", n_rise, 0);
        chk("bounce_clean", press_clean, 1'b0);

        // long press: held 20 cycles after the raw edge
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        chk("long_held_level", held, LONG_EN);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk_int("long_count", n_long, LONG_EN ? 1 : 0);
        chk_int("long_fall_count", n_fall, 1);
        chk("long_held_after_fall", held, 1'b0);

        // release bounce while pressed
        clear_counts();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk_int("relbounce_rise_count", n_rise, 1);
        chk_int("relbounce_fall_count", n_fall, 0);
        chk("relbounce_clean", press_clean, 1'b1);

        // reset mid-press with raw still high
        clear_counts();
        step(1'b1, 1'b1);
        chk("rst_clean_cleared", press_clean, 1'b0);
        rise_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            if (press_rise && rise_at < 0) rise_at = i;
        end
        chk_int("rst_rise_edge", rise_at, 7);
        chk_int("rst_fall_count", n_fall, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // randomised runs of random length with occasional resets
        lvl = 1'b0;
        for (int seg = 0; seg < 250; seg++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
